// File: rtl/spi_host_loader.sv
// spi_host_loader: single-lane SPI mode-0 master that turns word read/write
// requests into frames of cmd(8) + addr(32) + [dummy] + data(32), MSB first.
// Optional read support is enabled by defining SPI_LOADER_READ_EN; without it
// every request becomes a write frame and rsp_rdata_o is tied to zero.
module spi_host_loader #(
    parameter int CLK_DIV      = 4,
    parameter int DUMMY_CYCLES = 32,
    parameter int CS_GAP       = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        spi_clk_o,
    output logic        spi_csn_o,
    output logic        spi_sdo_o,
    input  logic        spi_sdi_i
);

`ifdef SPI_LOADER_READ_EN
    localparam bit READ_EN = 1'b1;
`else
    localparam bit READ_EN = 1'b0;
`endif

    localparam int HW = $clog2(CLK_DIV) + 1;
    localparam int GW = $clog2(CS_GAP) + 1;
    localparam logic [HW-1:0] HALF_LAST  = HW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'(CS_GAP - 1);
    localparam logic [5:0]    DUMMY_LAST = 6'(DUMMY_CYCLES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CMD   = 3'd1;
    localparam logic [2:0] S_ADDR  = 3'd2;
    localparam logic [2:0] S_DUMMY = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [5:0]    bcnt_q, bcnt_d;
    logic [GW-1:0] gcnt_q, gcnt_d;
    logic          sck_q, sck_d;
    logic          csn_q, csn_d;
    logic          sdo_q, sdo_d;
    logic          rsp_q, rsp_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rx_q, rx_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [7:0]    cmd_d;
    logic          tx_upd;

    // Frame sequencer: half-period timing, bit counting, phase transitions and
    // the next MOSI bit, which is only loaded at frame start or on SCK fall.
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        bcnt_d  = bcnt_q;
        gcnt_d  = gcnt_q;
        sck_d   = sck_q;
        csn_d   = csn_q;
        rsp_d   = 1'b0;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rx_d    = rx_q;
        rdata_d = rdata_q;
        tx_upd  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    we_d    = READ_EN ? req_we_i : 1'b1;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    state_d = S_CMD;
                    bcnt_d  = 6'd7;
                    hcnt_d  = HALF_LAST;
                    csn_d   = 1'b0;
                    sck_d   = 1'b0;
                    tx_upd  = 1'b1;
                end
            end
            S_GAP: begin
                if (gcnt_q == '0) state_d = S_IDLE;
                else              gcnt_d  = gcnt_q - 1'b1;
            end
            default: begin
                if (hcnt_q != '0) begin
                    hcnt_d = hcnt_q - 1'b1;
                end else begin
                    hcnt_d = HALF_LAST;
                    sck_d  = ~sck_q;
                    if (!sck_q) begin
                        // rising edge: capture MISO only in read data phase
                        if (READ_EN && state_q == S_DATA && !we_q)
                            rx_d = {rx_q[30:0], spi_sdi_i};
                    end else begin
                        // falling edge: advance to the next bit / phase
                        tx_upd = 1'b1;
                        if (bcnt_q != '0) begin
                            bcnt_d = bcnt_q - 1'b1;
                        end else begin
                            case (state_q)
                                S_CMD: begin
                                    state_d = S_ADDR;
                                    bcnt_d  = 6'd31;
                                end
                                S_ADDR: begin
                                    if (!we_q && DUMMY_CYCLES > 0) begin
                                        state_d = S_DUMMY;
                                        bcnt_d  = DUMMY_LAST;
                                    end else begin
                                        state_d = S_DATA;
                                        bcnt_d  = 6'd31;
                                    end
                                end
                                S_DUMMY: begin
                                    state_d = S_DATA;
                                    bcnt_d  = 6'd31;
                                end
                                default: begin
                                    // last bit done: CS rises with this SCK fall
                                    state_d = S_GAP;
                                    gcnt_d  = GAP_LAST;
                                    csn_d   = 1'b1;
                                    rsp_d   = 1'b1;
                                    if (READ_EN && !we_q) rdata_d = rx_q;
                                end
                            endcase
                        end
                    end
                end
            end
        endcase
        cmd_d = we_d ? 8'h02 : 8'h0B;
        sdo_d = sdo_q;
        if (tx_upd) begin
            case (state_d)
                S_CMD:   sdo_d = cmd_d[bcnt_d[2:0]];
                S_ADDR:  sdo_d = addr_d[bcnt_d[4:0]];
                S_DATA:  sdo_d = we_d & wdata_d[bcnt_d[4:0]];
                default: sdo_d = 1'b0;
            endcase
        end
    end

    // State registers; reset drops the frame and forces idle bus levels at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            hcnt_q  <= '0;
            bcnt_q  <= '0;
            gcnt_q  <= '0;
            sck_q   <= 1'b0;
            csn_q   <= 1'b1;
            sdo_q   <= 1'b0;
            rsp_q   <= 1'b0;
            we_q    <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            bcnt_q  <= bcnt_d;
            gcnt_q  <= gcnt_d;
            sck_q   <= sck_d;
            csn_q   <= csn_d;
            sdo_q   <= sdo_d;
            rsp_q   <= rsp_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
        end
    end

    assign req_ready_o = (state_q == S_IDLE);
    assign rsp_valid_o = rsp_q;
    assign rsp_rdata_o = READ_EN ? rdata_q : 32'h0;
    assign spi_clk_o   = sck_q;
    assign spi_csn_o   = csn_q;
    assign spi_sdo_o   = sdo_q;

endmodule

// File: tb/tb_spi_host_loader.sv
// Bench for spi_host_loader: randomized requests, an SPI slave/decoder that
// rebuilds each frame from the bus and compares it with the queued request.
module tb_spi_host_loader;
    localparam int CLK_DIV = 4;
    localparam int DUMMY   = 32;
    localparam int CS_GAP  = 4;
`ifdef SPI_LOADER_READ_EN
    localparam bit READ_EN = 1'b1;
`else
    localparam bit READ_EN = 1'b0;
`endif

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] sdata;
        bit          b2b;
    } item_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_i, req_ready_o, req_we_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        spi_clk_o, spi_csn_o, spi_sdo_o, spi_sdi_i;

    int n_chk = 0;
    int n_err = 0;

    item_t exp_q[$];
    item_t cur;
    bit    bits[$];
    bit    in_frame, prev_csn, prev_sck, prev_sdo, gap_track;
    int    low_cnt, last_rise, glitch, per_bad, hi_run;
    int    rdy_bad, stray, idle_bad;
    logic [31:0] last_rd;

    spi_host_loader #(.CLK_DIV(CLK_DIV), .DUMMY_CYCLES(DUMMY), .CS_GAP(CS_GAP)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
        .spi_clk_o(spi_clk_o), .spi_csn_o(spi_csn_o), .spi_sdo_o(spi_sdo_o),
        .spi_sdi_i(spi_sdi_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slave model: decodes each frame from the pins and checks it against the
    // oldest outstanding request; also serves read data on MISO.
    always @(negedge clk) begin
        bit fr_end;
        int n, idx;
        logic [7:0]  cmd;
        logic [31:0] a, d;
        bit dz;
        fr_end = 1'b0;
        if (!rst_n) begin
            in_frame = 0; prev_csn = 1; prev_sck = 0; prev_sdo = 0;
            gap_track = 0; hi_run = 0; last_rd = '0; spi_sdi_i = 1'b0;
        end else begin
            if (prev_csn && !spi_csn_o) begin
                in_frame = 1; low_cnt = 0; last_rise = 0; glitch = 0; per_bad = 0;
                bits.delete();
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                    cur = '{default: '0};
                end else cur = exp_q[0];
                if (cur.b2b) chk("cs_gap", hi_run, CS_GAP + 1);
                gap_track = 0;
            end
            if (in_frame && !spi_csn_o) begin
                low_cnt++;
                if (spi_clk_o && spi_sdo_o != prev_sdo) glitch++;
                if (spi_clk_o && !prev_sck) begin
                    bits.push_back(spi_sdo_o);
                    if (bits.size() == 1 && low_cnt != CLK_DIV + 1) per_bad++;
                    if (bits.size() > 1 && low_cnt - last_rise != 2 * CLK_DIV) per_bad++;
                    last_rise = low_cnt;
                end
                if (!spi_clk_o) begin
                    idx = int'(bits.size()) - 40 - DUMMY;
                    if (!cur.we && idx >= 0 && idx < 32) spi_sdi_i = cur.sdata[31 - idx];
                    else spi_sdi_i = 1'($urandom);
                end
            end else if (in_frame && spi_csn_o) begin
                fr_end = 1'b1;
                n = cur.we ? 72 : 72 + DUMMY;
                chk("cs_low_cycles", low_cnt, n * 2 * CLK_DIV);
                chk("frame_bits", bits.size(), n);
                if (bits.size() == n) begin
                    cmd = '0; a = '0; d = '0; dz = 0;
                    for (int i = 0; i < 8; i++)  cmd = {cmd[6:0], bits[i]};
                    for (int i = 8; i < 40; i++) a = {a[30:0], bits[i]};
                    for (int i = n - 32; i < n; i++) d = {d[30:0], bits[i]};
                    for (int i = 40; i < n; i++) dz = dz | bits[i];
                    chk("cmd", cmd, cur.we ? 8'h02 : 8'h0B);
                    chk("addr", a, cur.addr);
                    if (cur.we) chk("wdata", d, cur.wdata);
                    else        chk("rd_sdo_zero", dz, 0);
                end
                if (READ_EN && !cur.we) last_rd = cur.sdata;
                chk("rsp_valid", rsp_valid_o, 1);
                chk("sck_low_at_end", spi_clk_o, 0);
                chk("rsp_rdata", rsp_rdata_o, last_rd);
                chk("sdo_stable_sck_high", glitch, 0);
                chk("bit_period", per_bad, 0);
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                in_frame = 0; hi_run = 1; gap_track = 1;
            end else if (spi_csn_o) begin
                hi_run++;
            end
            if (spi_csn_o && gap_track) begin
                if (hi_run <= CS_GAP && req_ready_o) rdy_bad++;
                if (hi_run == CS_GAP + 1) begin
                    if (!req_ready_o) rdy_bad++;
                    gap_track = 0;
                end
            end
            if (rsp_valid_o && !fr_end) stray++;
            if (spi_csn_o && (spi_clk_o || spi_sdo_o)) idle_bad++;
            if (!in_frame) spi_sdi_i = 1'($urandom);
            prev_csn = spi_csn_o; prev_sck = spi_clk_o; prev_sdo = spi_sdo_o;
        end
    end

    // Issue one request; keep=1 leaves valid high so the next one follows
    // back-to-back. Fields are scrambled after the handshake.
    task automatic send(input bit we, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] sd, input bit keep, input bit b2b);
        item_t it;
        int n;
        @(negedge clk);
        req_valid_i = 1'b1; req_we_i = we; req_addr_i = a; req_wdata_i = d;
        n = 0;
        while (!req_ready_o && n < 3000) begin @(negedge clk); n++; end
        if (n >= 3000) chk("handshake_timeout", 0, 1);
        it.we = READ_EN ? we : 1'b1; it.addr = a; it.wdata = d; it.sdata = sd; it.b2b = b2b;
        exp_q.push_back(it);
        @(posedge clk); #1;
        req_we_i = ~we; req_addr_i = $urandom; req_wdata_i = $urandom;
        if (!keep) req_valid_i = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin @(negedge clk); n++; end
        if (n >= 3000) begin
            chk("frame_timeout", 0, 1);
            exp_q.delete();
        end
        repeat (CS_GAP + 2) @(negedge clk);
    endtask

    initial begin
        bit kp, pk;
        int n;
        rst_n = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0;
        req_addr_i = '0; req_wdata_i = '0;
        rdy_bad = 0; stray = 0; idle_bad = 0;
        repeat (3) @(negedge clk);
        chk("rst_csn", spi_csn_o, 1);
        chk("rst_sck", spi_clk_o, 0);
        chk("rst_sdo", spi_sdo_o, 0);
        chk("rst_ready", req_ready_o, 1);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_rdata", rsp_rdata_o, 0);
        @(posedge clk); #2 rst_n = 1'b1;

        // directed write and read (read degrades to write when disabled)
        send(1'b1, 32'h0010_0000, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
        wait_done();
        send(1'b0, 32'h0000_0080, 32'hA5A5_5A5A, 32'h1234_5678, 1'b0, 1'b0);
        wait_done();

        // back-to-back writes with valid held high
        send(1'b1, 32'hCAFE_0004, 32'h0BAD_F00D, 32'h0, 1'b1, 1'b0);
        send(1'b1, 32'h1357_9BDF, 32'h2468_ACE0, 32'h0, 1'b0, 1'b1);
        wait_done();

        // randomized mix
        pk = 1'b0;
        for (int i = 0; i < 10; i++) begin
            kp = (i != 9) && ($urandom_range(0, 1) == 1);
            send(1'($urandom), $urandom, $urandom, $urandom, kp, pk);
            pk = kp;
        end
        wait_done();

        // reset in the middle of the address phase
        send(1'b1, 32'hFFFF_0000, 32'h7777_8888, 32'h0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        n = 0;
        while (bits.size() < 18 && n < 3000) begin @(negedge clk); n++; end
        if (n >= 3000) chk("addr_bit_timeout", 0, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_csn", spi_csn_o, 1);
        chk("midrst_sck", spi_clk_o, 0);
        chk("midrst_sdo", spi_sdo_o, 0);
        chk("midrst_ready", req_ready_o, 1);
        chk("midrst_rsp_valid", rsp_valid_o, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        send(1'b1, 32'h0000_0100, 32'h5555_AAAA, 32'h0, 1'b0, 1'b0);
        wait_done();

        chk("ready_gap_timing", rdy_bad, 0);
        chk("stray_rsp_valid", stray, 0);
        chk("idle_bus_levels", idle_bad, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
